// File: rtl/cell_particle_reader.sv
// Read sequencer for one cell position memory: fetches the count word,
// then streams particle words 1..N through a credit-limited show-ahead FIFO.
module cell_particle_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int SW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_CNT,
    S_WAIT_CNT,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [ADDR_WIDTH-1:0] next_q, next_d;
  logic [ADDR_WIDTH-1:0] xfer_q, xfer_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;

  logic                  sr_vld_q  [RD_LATENCY];
  logic                  sr_vld_d  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] sr_addr_q [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] sr_addr_d [RD_LATENCY];

  logic [DATA_WIDTH-1:0] fd_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fd_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fp_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fp_d [FIFO_DEPTH];
  logic [PW-1:0]         rd_q, rd_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [CW-1:0]         fcnt_q, fcnt_d;

  logic                  issue;
  logic                  issue_pid;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] cnt_raw;
  logic [ADDR_WIDTH-1:0] cnt_clamp;
  logic [SW-1:0]         inflight;
  logic                  credit_ok;
  logic                  push;
  logic                  pop;
  logic                  drained;

  assign cnt_raw   = mem_q[ADDR_WIDTH-1:0];
  assign cnt_clamp = (cnt_raw > MAX_CNT) ? MAX_CNT : cnt_raw;

  assign out_valid = (fcnt_q != '0);
  assign out_data  = fd_q[rd_q];
  assign out_pid   = fp_q[rd_q];
  assign pop       = out_valid && out_ready;
  assign push      = sr_vld_q[RD_LATENCY-1];

  // every in-flight read owns a FIFO slot, so a return can never overflow
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + SW'(sr_vld_q[i]);
    end
  end

  assign credit_ok = (inflight + SW'(fcnt_q)) < SW'(FIFO_DEPTH);
  assign drained   = ((xfer_q + ADDR_WIDTH'(pop)) == count_q) &&
                     (inflight == '0) && (fcnt_q == CW'(pop));

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    count_d    = count_q;
    next_d     = next_q;
    xfer_d     = pop ? xfer_q + ADDR_WIDTH'(1) : xfer_q;
    issue      = 1'b0;
    issue_pid  = 1'b0;
    issue_addr = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ_CNT;
      end
      S_REQ_CNT: begin
        issue      = 1'b1;
        issue_addr = '0;
        wait_d     = '0;
        xfer_d     = '0;
        state_d    = S_WAIT_CNT;
      end
      S_WAIT_CNT: begin
        if (wait_q == WW'(RD_LATENCY - 1)) begin
          count_d = cnt_clamp;
          next_d  = ADDR_WIDTH'(1);
          state_d = (cnt_clamp == '0) ? S_DRAIN : S_STREAM;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_STREAM: begin
        if (credit_ok) begin
          issue      = 1'b1;
          issue_pid  = 1'b1;
          issue_addr = next_q;
          next_d     = next_q + ADDR_WIDTH'(1);
          if (next_q == count_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    last_d = issue_addr;
  end

  assign mem_rden       = issue;
  assign mem_address    = issue_addr;
  assign busy           = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done           = (state_q == S_FIN);
  assign particle_count = count_q;

  always_comb begin
    sr_vld_d[0]  = issue_pid;
    sr_addr_d[0] = issue_addr;
    for (int i = 1; i < RD_LATENCY; i++) begin
      sr_vld_d[i]  = sr_vld_q[i-1];
      sr_addr_d[i] = sr_addr_q[i-1];
    end
  end

  always_comb begin
    fd_d = fd_q;
    fp_d = fp_q;
    rd_d = rd_q;
    wr_d = wr_q;
    if (push) begin
      fd_d[wr_q] = mem_q;
      fp_d[wr_q] = sr_addr_q[RD_LATENCY-1];
      wr_d = (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end
    fcnt_d = fcnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      count_q <= '0;
      next_q  <= '0;
      xfer_q  <= '0;
      last_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      fcnt_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        sr_vld_q[i]  <= 1'b0;
        sr_addr_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fd_q[i] <= '0;
        fp_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
      next_q    <= next_d;
      xfer_q    <= xfer_d;
      last_q    <= last_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      fcnt_q    <= fcnt_d;
      sr_vld_q  <= sr_vld_d;
      sr_addr_q <= sr_addr_d;
      fd_q      <= fd_d;
      fp_q      <= fp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && fcnt_q == CW'(FIFO_DEPTH)));
    end
  end

endmodule

// File: tb/tb_cell_particle_reader.sv
// Bench for cell_particle_reader: memory model plus queue-based
// reference of the expected particle stream and scan timing.
module tb_cell_particle_reader;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          mem_rden;
  logic          out_valid;
  logic [AW-1:0] particle_count;
  logic [AW-1:0] mem_address;
  logic [AW-1:0] out_pid;
  logic [DW-1:0] mem_q = '0;
  logic [DW-1:0] out_data;

  logic [DW-1:0] mem [0:PN-1];
  logic [DW-1:0] p1 = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rmode = 0;
  int rph = 0;

  int exp_q[$];
  int exp_n = 0;
  int issued = 0;
  int xfers = 0;
  int last_issue = 0;
  int zero_reads = 0;
  int cnt_cyc = 0;
  bit cnt_seen = 0;
  bit pending_done = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] prev_pid = '0;

  always #5 clk = ~clk;

  cell_particle_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .particle_count (particle_count),
    .mem_address    (mem_address),
    .mem_rden       (mem_rden),
    .mem_q          (mem_q),
    .out_data       (out_data),
    .out_pid        (out_pid),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  // two-cycle read latency memory
  always @(posedge clk) begin
    if (mem_rden) p1 <= mem[mem_address];
    mem_q <= p1;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (rph % 4 == 0) || (rph % 4 == 3);
          rph++;
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pending_done = 0;
      cnt_seen = 0;
      prev_stall = 0;
    end else begin
      if (pending_done) begin
        chk("done_after_last", done, 1);
        pending_done = 0;
      end
      if (done) chk("done_with_words_left", exp_q.size(), 0);
      if (mem_rden) begin
        if (mem_address == 0) begin
          zero_reads++;
          cnt_seen = 1;
          cnt_cyc = cyc;
          issued = 0;
          xfers = 0;
          last_issue = 0;
        end else begin
          chk("rd_order", mem_address, last_issue + 1);
          chk("rd_range", mem_address <= exp_n, 1);
          last_issue = mem_address;
          issued++;
          chk("rd_credit", (issued - xfers) <= FD, 1);
        end
      end else if (cnt_seen && cyc >= cnt_cyc + 3 && issued < exp_n &&
                   (issued - xfers) < FD) begin
        chk("rd_missing", mem_rden, 1);
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
        chk("hold_pid", out_pid, prev_pid);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", out_valid, 0);
        end else begin
          chk("pid", out_pid, exp_q[0]);
          chk("data", out_data, mem[exp_q[0]]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            xfers++;
            if (exp_q.size() == 0) pending_done = 1;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      prev_pid = out_pid;
      if (done) cnt_seen = 0;
    end
  end

  task automatic setup(input logic [7:0] cw, output int n);
    for (int a = 0; a < PN; a++) mem[a] = {$urandom, $urandom, $urandom};
    mem[0][7:0] = cw;
    n = (int'(cw) > PN - 1) ? PN - 1 : int'(cw);
    exp_q.delete();
    for (int i = 1; i <= n; i++) exp_q.push_back(i);
    exp_n = n;
    zero_reads = 0;
  endtask

  task automatic run_scan(input logic [7:0] cw, input bit trace, input bit poke);
    int n;
    int dc;
    int budget;
    bit got;
    @(posedge clk);
    #1;
    setup(cw, n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    budget = (rmode == 0) ? n + 20 : 30 * n + 60;
    got = 0;
    dc = 0;
    for (int c = 1; c <= budget && !got; c++) begin
      start = poke && (c == 2 || (c == 8 && n >= 4));
      @(negedge clk);
      if (trace) begin
        chk("tr_rden", mem_rden, (c == 1) || (n > 0 && c >= 4 && c <= n + 3));
        if (mem_rden) chk("tr_addr", mem_address, (c == 1) ? 0 : c - 3);
        chk("tr_valid", out_valid, n > 0 && c >= 7 && c <= n + 6);
        chk("tr_busy", busy, c <= ((n == 0) ? 4 : n + 6));
        chk("tr_done", done, c == ((n == 0) ? 5 : n + 7));
      end
      if (done) begin
        got = 1;
        dc = c;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    chk("scan_timeout", got, 1);
    chk("scan_words_left", exp_q.size(), 0);
    chk("particle_count", particle_count, n);
    chk("count_reads", zero_reads, 1);
    if (rmode == 0) chk("done_cycle", dc, (n == 0) ? 5 : n + 7);
  endtask

  initial begin
    int n;
    bit ok;
    logic [7:0] cw;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", particle_count, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_rden", mem_rden, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_pid", out_pid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    rmode = 0;
    run_scan(8'd3, 1, 0);
    run_scan(8'd0, 1, 0);
    rmode = 1;
    run_scan(8'd10, 0, 0);
    rmode = 0;
    run_scan(8'd255, 1, 0);
    chk("last_addr", last_issue, 219);

    @(posedge clk);
    #1;
    setup(8'd50, n);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = cnt_seen && xfers >= 5;
    end
    chk("rst_reach_5", ok, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rden", mem_rden, 0);
    chk("midrst_done", done, 0);
    chk("midrst_pid", out_pid, 0);
    exp_q.delete();
    exp_n = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_scan(8'd2, 1, 0);

    run_scan(8'd10, 1, 1);
    run_scan(8'd4, 1, 0);

    rmode = 2;
    for (int k = 0; k < 12; k++) begin
      cw = (k % 4 == 3) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 24));
      run_scan(cw, 0, (k % 3) == 1);
    end
    rmode = 0;
    run_scan(8'd1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
